switch_bank_debounce: RTL and testbench

Parametrised, multi-channel successor to the single-channel front-panel debouncer. Each channel synchronises an asynchronous switch input, debounces it, and latches press, release and long-press events in sticky bits. Software clears those bits through a write-one-to-clear strobe. The block sits between the front-panel switch pins and the GPIO status/interrupt path, so firmware no longer has to poll or debounce switches itself.

---
 rtl/switch_bank_pkg.sv | 22 ++
 rtl/switch_debounce_channel.sv | 115 +++++++++++
 rtl/switch_bank_debounce.sv | 103 ++++++++++
 tb/tb_switch_bank_debounce.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/switch_bank_pkg.sv
// Shared types, status field offsets and cycle-count helper for switch_bank_debounce.
// Long-press logic is built only when SWITCH_LONG_PRESS_EN is defined.
package switch_bank_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StTiming,
        StFired
    } long_state_e;

    localparam int unsigned LEVEL_LSB   = 0;
    localparam int unsigned PRESS_LSB   = 8;
    localparam int unsigned RELEASE_LSB = 16;
    localparam int unsigned LONG_LSB    = 24;

    // Cycles per millisecond is rounded up so short timings never undershoot.
    function automatic int unsigned ms_to_cycles(input int unsigned clk_rate,
                                                 input int unsigned ms);
        return ((clk_rate + 32'd999) / 32'd1000) * ms;
    endfunction

endpackage

// File: rtl/switch_debounce_channel.sv
// One switch channel: polarity fix, 2-flop sync, debounce counter, level and event pulses.
// The long-press FSM exists only when SWITCH_LONG_PRESS_EN is defined.
module switch_debounce_channel
    import switch_bank_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 10,
`ifdef SWITCH_LONG_PRESS_EN
    parameter int unsigned LONG_CYCLES     = 30,
`endif
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic switch_a,
    output logic level,
    output logic pressPulse,
    output logic releasePulse,
    output logic longPulse
);

    localparam int unsigned      DEB_W      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DEB_W-1:0] DEB_RELOAD = DEB_W'(DEBOUNCE_CYCLES - 1);

    logic             pin;
    logic             sync1_q, sync2_q, d1_q;
    logic             level_q, level_d;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;

    assign pin = switch_a ^ ACTIVE_LOW;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            d1_q      <= 1'b0;
            deb_cnt_q <= DEB_RELOAD;
            level_q   <= 1'b0;
        end else begin
            sync1_q   <= pin;
            sync2_q   <= sync1_q;
            d1_q      <= sync2_q;
            deb_cnt_q <= deb_cnt_d;
            level_q   <= level_d;
        end
    end

    // Counter parks at zero once expired, so the level keeps tracking a stable pin.
    always_comb begin
        deb_cnt_d = deb_cnt_q;
        level_d   = level_q;
        if (sync2_q != d1_q) begin
            deb_cnt_d = DEB_RELOAD;
        end else if (deb_cnt_q != '0) begin
            deb_cnt_d = deb_cnt_q - DEB_W'(1);
        end else begin
            level_d = sync2_q;
        end
    end

    assign level        = level_q;
    assign pressPulse   = level_d & ~level_q;
    assign releasePulse = ~level_d & level_q;

`ifdef SWITCH_LONG_PRESS_EN
    localparam int unsigned       LONG_W      = $clog2(LONG_CYCLES + 1);
    localparam logic [LONG_W-1:0] LONG_RELOAD = LONG_W'(LONG_CYCLES - 1);

    long_state_e       lp_state_q, lp_state_d;
    logic [LONG_W-1:0] lp_cnt_q, lp_cnt_d;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lp_state_q <= StIdle;
            lp_cnt_q   <= LONG_RELOAD;
        end else begin
            lp_state_q <= lp_state_d;
            lp_cnt_q   <= lp_cnt_d;
        end
    end

    // A release landing on the expiry cycle wins: no long-press for that press.
    always_comb begin
        lp_state_d = lp_state_q;
        lp_cnt_d   = lp_cnt_q;
        longPulse  = 1'b0;
        unique case (lp_state_q)
            StIdle: begin
                if (pressPulse) begin
                    lp_state_d = StTiming;
                    lp_cnt_d   = LONG_RELOAD;
                end
            end
            StTiming: begin
                if (releasePulse) begin
                    lp_state_d = StIdle;
                end else if (lp_cnt_q == '0) begin
                    lp_state_d = StFired;
                    longPulse  = 1'b1;
                end else begin
                    lp_cnt_d = lp_cnt_q - LONG_W'(1);
                end
            end
            StFired: begin
                if (releasePulse) begin
                    lp_state_d = StIdle;
                end
            end
            default: lp_state_d = StIdle;
        endcase
    end
`else
    assign longPulse = 1'b0;
`endif

endmodule

// File: rtl/switch_bank_debounce.sv
// Multi-channel switch debouncer with sticky press/release/long-press events and W1C clear.
// Long-press events (status[31:24]) are built only when SWITCH_LONG_PRESS_EN is defined.
module switch_bank_debounce
    import switch_bank_pkg::*;
#(
    parameter int unsigned         CHANNELS      = 4,
    parameter int unsigned         CLK_RATE      = 100000000,
    parameter int unsigned         DEBOUNCE_MS   = 10,
    parameter int unsigned         LONG_PRESS_MS = 2000,
    parameter logic [CHANNELS-1:0] ACTIVE_LOW    = {CHANNELS{1'b1}}
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [CHANNELS-1:0] switch_a,
    input  logic                csrStrobe,
    input  logic [31:0]         csrData,
    output logic [31:0]         status,
    output logic                irq
);

    localparam int unsigned DEBOUNCE_CYCLES = ms_to_cycles(CLK_RATE, DEBOUNCE_MS);
`ifdef SWITCH_LONG_PRESS_EN
    localparam int unsigned LONG_CYCLES     = ms_to_cycles(CLK_RATE, LONG_PRESS_MS);
`endif

    logic [CHANNELS-1:0] level;
    logic [CHANNELS-1:0] press_set, release_set, long_set;
    logic [CHANNELS-1:0] press_q, release_q, long_q;
    logic [CHANNELS-1:0] press_d, release_d;
    logic [CHANNELS-1:0] press_clr, release_clr;
    logic                irq_q;
    logic                unused_bits;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        switch_debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
`ifdef SWITCH_LONG_PRESS_EN
            .LONG_CYCLES    (LONG_CYCLES),
`endif
            .ACTIVE_LOW     (ACTIVE_LOW[i])
        ) u_chan (
            .clk         (clk),
            .reset_n     (reset_n),
            .switch_a    (switch_a[i]),
            .level       (level[i]),
            .pressPulse  (press_set[i]),
            .releasePulse(release_set[i]),
            .longPulse   (long_set[i])
        );
    end

    assign press_clr   = csrStrobe ? csrData[PRESS_LSB +: CHANNELS]   : '0;
    assign release_clr = csrStrobe ? csrData[RELEASE_LSB +: CHANNELS] : '0;

    // Set is OR-ed in after the clear so a simultaneous event is never lost.
    always_comb begin
        press_d   = (press_q & ~press_clr) | press_set;
        release_d = (release_q & ~release_clr) | release_set;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            press_q   <= '0;
            release_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            press_q   <= press_d;
            release_q <= release_d;
            irq_q     <= |{press_q, release_q, long_q};
        end
    end

`ifdef SWITCH_LONG_PRESS_EN
    logic [CHANNELS-1:0] long_d, long_clr;

    assign long_clr = csrStrobe ? csrData[LONG_LSB +: CHANNELS] : '0;
    assign long_d   = (long_q & ~long_clr) | long_set;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            long_q <= '0;
        end else begin
            long_q <= long_d;
        end
    end

    assign unused_bits = ^csrData;
`else
    assign long_q      = '0;
    assign unused_bits = ^{csrData, long_set, LONG_PRESS_MS[0]};
`endif

    always_comb begin
        status = '0;
        status[LEVEL_LSB +: CHANNELS]   = level;
        status[PRESS_LSB +: CHANNELS]   = press_q;
        status[RELEASE_LSB +: CHANNELS] = release_q;
        status[LONG_LSB +: CHANNELS]    = long_q;
    end

    assign irq = irq_q;

endmodule

// File: tb/tb_switch_bank_debounce.sv
// Bench for switch_bank_debounce: directed step table, hand sequences, random run vs model.
module tb_switch_bank_debounce;

    localparam int unsigned CH    = 4;
    localparam int unsigned LONGC = 30;
`ifdef SWITCH_LONG_PRESS_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif
    localparam logic [31:0] L2 = LONG_EN ? 32'h0400_0000 : 32'h0;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [CH-1:0] switch_a;
    logic          csrStrobe;
    logic [31:0]   csrData;
    logic [31:0]   status;
    logic          irq;

    always #5 clk = ~clk;

    switch_bank_debounce #(
        .CHANNELS     (CH),
        .CLK_RATE     (10000),
        .DEBOUNCE_MS  (1),
        .LONG_PRESS_MS(3),
        .ACTIVE_LOW   (4'hF)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .switch_a (switch_a),
        .csrStrobe(csrStrobe),
        .csrData  (csrData),
        .status   (status),
        .irq      (irq)
    );

    int total = 0;
    int bad   = 0;

    // Reference: level follows the pin once its last 11 synchronised samples agree.
    logic [12:0]   win [CH];
    int            held [CH];
    logic [CH-1:0] m_level, m_press, m_rel, m_long;
    logic          m_irq;

    function automatic logic [31:0] m_status();
        return {4'b0, m_long, 4'b0, m_rel, 4'b0, m_press, 4'b0, m_level};
    endfunction

    task automatic model_step();
        logic [CH-1:0] nl, sp, sr, sl, cp, cr, cl;
        if (!reset_n) begin
            for (int c = 0; c < CH; c++) begin
                win[c]  = '0;
                held[c] = 0;
            end
            m_level = '0;
            m_press = '0;
            m_rel   = '0;
            m_long  = '0;
            m_irq   = 1'b0;
            return;
        end
        m_irq = |{m_press, m_rel, m_long};
        sl    = '0;
        for (int c = 0; c < CH; c++) begin
            win[c] = {win[c][11:0], ~switch_a[c]};
            nl[c]  = (win[c][12:2] == '0 || win[c][12:2] == '1) ? win[c][2] : m_level[c];
            if (nl[c] && !m_level[c]) held[c] = 0;
            else if (nl[c]) held[c]++;
            sl[c] = LONG_EN && nl[c] && m_level[c] && (held[c] == LONGC);
        end
        sp = nl & ~m_level;
        sr = ~nl & m_level;
        cp = csrStrobe ? csrData[11:8]  : '0;
        cr = csrStrobe ? csrData[19:16] : '0;
        cl = csrStrobe ? csrData[27:24] : '0;
        m_press = (m_press & ~cp) | sp;
        m_rel   = (m_rel & ~cr) | sr;
        m_long  = (m_long & ~cl) | sl;
        m_level = nl;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check({tag, " status vs model"}, status, m_status());
        check({tag, " irq vs model"}, {31'b0, irq}, {31'b0, m_irq});
    endtask

    typedef struct {
        logic        rst_n;
        logic [3:0]  sw;
        logic        stb;
        logic [31:0] data;
        int          n;
        logic [31:0] st;
        logic        iq;
    } step_t;

    step_t tab[$];

    task automatic add(input logic rst, input logic [3:0] sw, input logic stb,
                       input logic [31:0] data, input int n, input logic [31:0] st,
                       input logic iq);
        step_t s;
        s = '{rst, sw, stb, data, n, st, iq};
        tab.push_back(s);
    endtask

    task automatic run_table(input string tname);
        for (int i = 0; i < tab.size(); i++) begin
            reset_n   = tab[i].rst_n;
            switch_a  = tab[i].sw;
            csrStrobe = tab[i].stb;
            csrData   = tab[i].data;
            repeat (tab[i].n) tick(tname);
            check($sformatf("%s[%0d] status", tname, i), status, tab[i].st);
            check($sformatf("%s[%0d] irq", tname, i), {31'b0, irq}, {31'b0, tab[i].iq});
        end
        csrStrobe = 1'b0;
        csrData   = '0;
    endtask

    initial begin
        reset_n   = 1'b0;
        switch_a  = 4'hF;
        csrStrobe = 1'b0;
        csrData   = '0;
        tick("reset");
        tick("reset");

        // Idle after reset, then ch0 press and a plain clear.
        add(1, 4'hF, 0, 32'h0,   100, 32'h0,   0);
        add(1, 4'hE, 0, 32'h0,   12,  32'h0,   0);
        add(1, 4'hE, 0, 32'h0,   1,   32'h101, 0);
        add(1, 4'hE, 0, 32'h0,   1,   32'h101, 1);
        add(1, 4'hE, 1, 32'h100, 1,   32'h001, 1);
        add(1, 4'hE, 0, 32'h0,   1,   32'h001, 0);
        run_table("press");

        // ch1 bounces every 5 cycles, then settles pressed.
        for (int t = 0; t < 12; t++) begin
            switch_a[1] = ~switch_a[1];
            repeat (5) tick("bounce");
            check($sformatf("bounce[%0d] status", t), status, 32'h001);
        end
        switch_a[1] = 1'b0;
        repeat (12) tick("settle");
        check("settle early status", status, 32'h001);
        tick("settle");
        check("settle status", status, 32'h203);
        check("settle irq early", {31'b0, irq}, 32'h0);
        tick("settle");
        check("settle irq", {31'b0, irq}, 32'h1);

        tab.delete();
        add(1, 4'hC, 1, 32'h200, 1,  32'h003, 1);
        add(1, 4'hC, 0, 32'h0,   1,  32'h003, 0);
        // 50-cycle hold of ch2: long press 30 cycles after the level rise.
        add(1, 4'h8, 0, 32'h0,   13, 32'h407, 0);
        add(1, 4'h8, 0, 32'h0,   1,  32'h407, 1);
        add(1, 4'h8, 0, 32'h0,   28, 32'h407, 1);
        add(1, 4'h8, 0, 32'h0,   1,  32'h407 | L2, 1);
        add(1, 4'h8, 0, 32'h0,   7,  32'h407 | L2, 1);
        add(1, 4'hC, 0, 32'h0,   12, 32'h407 | L2, 1);
        add(1, 4'hC, 0, 32'h0,   1,  32'h0004_0403 | L2, 1);
        add(1, 4'hC, 1, 32'hFFFF_FFFF, 1, 32'h003, 1);
        add(1, 4'hC, 0, 32'h0,   1,  32'h003, 0);
        // 20-cycle hold: press and release only.
        add(1, 4'h8, 0, 32'h0,   13, 32'h407, 0);
        add(1, 4'h8, 0, 32'h0,   7,  32'h407, 1);
        add(1, 4'hC, 0, 32'h0,   13, 32'h0004_0403, 1);
        add(1, 4'hC, 0, 32'h0,   20, 32'h0004_0403, 1);
        add(1, 4'hC, 1, 32'hFFFF_FFFF, 1, 32'h003, 1);
        add(1, 4'hC, 0, 32'h0,   1,  32'h003, 0);
        // Clear colliding with a new ch0 press: the set wins.
        add(1, 4'hD, 0, 32'h0,   13, 32'h0001_0002, 0);
        add(1, 4'hD, 0, 32'h0,   1,  32'h0001_0002, 1);
        add(1, 4'hD, 1, 32'hFFFF_FFFF, 1, 32'h002, 1);
        add(1, 4'hD, 0, 32'h0,   1,  32'h002, 0);
        add(1, 4'hC, 0, 32'h0,   12, 32'h002, 0);
        add(1, 4'hC, 1, 32'h100, 1,  32'h103, 0);
        add(1, 4'hC, 0, 32'h0,   1,  32'h103, 1);
        add(1, 4'hC, 1, 32'h100, 1,  32'h003, 1);
        add(1, 4'hC, 0, 32'h0,   1,  32'h003, 0);
        // Reset mid-debounce; the cleared pipeline refills, so held pins look like new edges.
        add(1, 4'h4, 0, 32'h0,   5,  32'h003, 0);
        add(0, 4'h4, 0, 32'h0,   1,  32'h0,   0);
        add(1, 4'h4, 0, 32'h0,   12, 32'h0,   0);
        add(1, 4'h4, 0, 32'h0,   1,  32'h0B0B, 0);
        add(1, 4'h4, 0, 32'h0,   1,  32'h0B0B, 1);
        run_table("seq");

        // Random phase alternating calm and bouncy stretches.
        for (int i = 0; i < 4000; i++) begin
            int          idx;
            int unsigned odds;
            odds = ((i / 500) % 2 == 0) ? 100 : 4;
            if ($urandom_range(0, odds - 1) == 0) begin
                idx           = $urandom_range(0, CH - 1);
                switch_a[idx] = ~switch_a[idx];
            end
            csrStrobe = ($urandom_range(0, 15) == 0);
            csrData   = $urandom;
            reset_n   = ($urandom_range(0, 999) != 0);
            tick("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
